// File: rtl/slv_ram_arbiter_if.sv
// Bus bundle for slv_ram_arbiter: PCIe slave side, local req/gnt side and RAM side.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface slv_ram_arbiter_if #(
  parameter int ADR_W = 14
);
  logic             p_ce;
  logic             p_we;
  logic [ADR_W-1:0] p_adr;
  logic [15:0]      p_dat_i;
  logic [1:0]       p_sel;
  logic [15:0]      p_dat_o;

  logic             l_req;
  logic             l_we;
  logic [ADR_W-1:0] l_adr;
  logic [15:0]      l_dat_i;
  logic [1:0]       l_sel;
  logic             l_gnt;
  logic             l_rvalid;
  logic [15:0]      l_dat_o;

  logic             m_ce;
  logic             m_we;
  logic [ADR_W-1:0] m_adr;
  logic [15:0]      m_dat;
  logic [1:0]       m_sel;
  logic [15:0]      m_q;

  modport slave (
    input  p_ce, p_we, p_adr, p_dat_i, p_sel,
    output p_dat_o,
    input  l_req, l_we, l_adr, l_dat_i, l_sel,
    output l_gnt, l_rvalid, l_dat_o,
    output m_ce, m_we, m_adr, m_dat, m_sel,
    input  m_q
  );

  modport master (
    output p_ce, p_we, p_adr, p_dat_i, p_sel,
    input  p_dat_o,
    output l_req, l_we, l_adr, l_dat_i, l_sel,
    input  l_gnt, l_rvalid, l_dat_o,
    input  m_ce, m_we, m_adr, m_dat, m_sel,
    output m_q
  );
endinterface

// File: rtl/slv_ram_arbiter.sv
// Single-port BAR RAM arbiter: PCIe slave (absolute priority) > power-up clear sweep > local master.
// Optional saturating traffic statistics are built when ARB_STAT_EN is defined.
module slv_ram_arbiter #(
  parameter int ADR_W      = 14,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic                   clk_125,
  input  logic                   rstn,
  slv_ram_arbiter_if.slave       bus,
  output logic                   init_done,
  output logic                   l_starve
`ifdef ARB_STAT_EN
  ,
  input  logic                   stat_clr,
  output logic [15:0]            stat_p,
  output logic [15:0]            stat_l,
  output logic [15:0]            stat_stall
`endif
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic {OWN_PCIE, OWN_LOCAL} owner_t;
  typedef struct packed {
    logic   vld;
    owner_t owner;
  } tag_t;

  state_t              state;
  logic [ADR_W-1:0]    clr_adr;
  tag_t                tag [RD_LAT];
  tag_t                new_tag;
  tag_t                out_tag;
  logic                sweep_issue;
  logic                stall;
  logic [15:0]         p_hold;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    bus.m_ce    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_adr   = '0;
    bus.m_dat   = '0;
    bus.m_sel   = '0;
    bus.l_gnt   = 1'b0;
    sweep_issue = 1'b0;
    if (rstn) begin
      if (bus.p_ce) begin
        bus.m_ce  = 1'b1;
        bus.m_we  = bus.p_we;
        bus.m_adr = bus.p_adr;
        bus.m_dat = bus.p_dat_i;
        bus.m_sel = bus.p_sel;
      end else if (state == S_INIT) begin
        bus.m_ce    = 1'b1;
        bus.m_we    = 1'b1;
        bus.m_adr   = clr_adr;
        bus.m_sel   = 2'b11;
        sweep_issue = 1'b1;
      end else if (bus.l_req) begin
        bus.m_ce  = 1'b1;
        bus.m_we  = bus.l_we;
        bus.m_adr = bus.l_adr;
        bus.m_dat = bus.l_dat_i;
        bus.m_sel = bus.l_sel;
        bus.l_gnt = 1'b1;
      end
    end
  end

  assign new_tag.vld   = bus.m_ce & ~bus.m_we;
  assign new_tag.owner = bus.p_ce ? OWN_PCIE : OWN_LOCAL;
  assign out_tag       = tag[RD_LAT-1];

  assign bus.p_dat_o = (out_tag.vld && out_tag.owner == OWN_PCIE) ? bus.m_q : p_hold;

  assign stall      = bus.l_req & ~bus.l_gnt;
  assign starve_nxt = !stall ? '0 :
                      (starve_cnt == STARVE_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state        <= S_INIT;
      clr_adr      <= '0;
      init_done    <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
      p_hold       <= '0;
      bus.l_rvalid <= 1'b0;
      bus.l_dat_o  <= '0;
      starve_cnt   <= '0;
      l_starve     <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) tag[i] <= tag[i-1];
      tag[0] <= new_tag;

      // The sweep pointer only moves on cycles the sweep actually owned the RAM.
      if (sweep_issue) begin
        clr_adr <= clr_adr + 1'b1;
        if (&clr_adr) begin
          state     <= S_RUN;
          init_done <= 1'b1;
        end
      end

      if (out_tag.vld && out_tag.owner == OWN_PCIE) p_hold <= bus.m_q;
      bus.l_rvalid <= out_tag.vld && out_tag.owner == OWN_LOCAL;
      if (out_tag.vld && out_tag.owner == OWN_LOCAL) bus.l_dat_o <= bus.m_q;

      starve_cnt <= starve_nxt;
      l_starve   <= (starve_nxt == STARVE_W'(STARVE_MAX));
    end
  end

`ifdef ARB_STAT_EN
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      stat_p     <= '0;
      stat_l     <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_p     <= '0;
      stat_l     <= '0;
      stat_stall <= '0;
    end else if (state == S_RUN) begin
      if (bus.p_ce  && stat_p     != 16'hFFFF) stat_p     <= stat_p + 1'b1;
      if (bus.l_gnt && stat_l     != 16'hFFFF) stat_l     <= stat_l + 1'b1;
      if (stall     && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule
